// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug-stream and memory signals around the data-memory arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/debug/memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          cpu_re;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_start;
  logic          dbg_dir;
  logic [AW-1:0] dbg_base;
  logic [AW-1:0] dbg_len;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_wvalid;
  logic          dbg_wready;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic          dbg_busy;
  logic          dbg_done;
  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_start, dbg_dir, dbg_base, dbg_len, dbg_wdata, dbg_wvalid,
    input  mem_q,
    output cpu_rdata, cpu_stall,
    output dbg_wready, dbg_rdata, dbg_rvalid, dbg_busy, dbg_done,
    output mem_address, mem_we, mem_data
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output dbg_start, dbg_dir, dbg_base, dbg_len, dbg_wdata, dbg_wvalid,
    output mem_q,
    input  cpu_rdata, cpu_stall,
    input  dbg_wready, dbg_rdata, dbg_rvalid, dbg_busy, dbg_done,
    input  mem_address, mem_we, mem_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, the debug fill/dump channel gets a
// forced slot after STARVE_LIMIT consecutive denials.
module dmem_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FILL, DUMP, DONE} state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] ptr;
  logic [AW-1:0] cnt;
  logic [SW-1:0] starve;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          done_q;
  logic          busy_q;
  logic          cpu_req;
  logic          dbg_pend;
  logic          starve_force;
  logic          dbg_grant;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; dbg_start only matters in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (bus.dbg_start) state_n = bus.dbg_dir ? FILL : DUMP;
      FILL, DUMP: if (dbg_grant && (cnt == '0)) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Arbitration and memory mux
  always_comb begin
    cpu_req         = bus.cpu_re | bus.cpu_we;
    dbg_pend        = (state == DUMP) | ((state == FILL) & bus.dbg_wvalid);
    starve_force    = dbg_pend & (starve == SW'(STARVE_LIMIT));
    dbg_grant       = dbg_pend & (~cpu_req | starve_force);
    bus.cpu_stall   = cpu_req & dbg_grant;
    bus.dbg_wready  = dbg_grant & (state == FILL);
    bus.cpu_rdata   = bus.mem_q;
    bus.mem_address = bus.cpu_addr;
    bus.mem_we      = bus.cpu_we & ~reset;
    bus.mem_data    = bus.cpu_wdata;
    if (dbg_grant) begin
      bus.mem_address = ptr;
      bus.mem_we      = (state == FILL) & ~reset;
      bus.mem_data    = bus.dbg_wdata;
    end
  end

  // Transfer pointer/count, starve counter and registered stream outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= '0;
      cnt      <= '0;
      starve   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rvalid_q <= dbg_grant & (state == DUMP);
      if (dbg_grant && (state == DUMP)) rdata_q <= bus.mem_q;
      done_q <= (state_n == DONE);
      busy_q <= (state_n != IDLE);
      if ((state == IDLE) && bus.dbg_start) begin
        ptr <= bus.dbg_base;
        cnt <= bus.dbg_len;
      end else if (dbg_grant) begin
        ptr <= ptr + AW'(1);
        if (cnt != '0) cnt <= cnt - AW'(1);
      end
      // A gap in the fill stream leaves dbg_pend low, so the count holds
      if (((state != FILL) && (state != DUMP)) || dbg_grant)
        starve <= '0;
      else if (dbg_pend && (starve != SW'(STARVE_LIMIT)))
        starve <= starve + SW'(1);
    end
  end

  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_done   = done_q;
  assign bus.dbg_busy   = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus
// directed scenarios and a randomized soak.
module tb_dmem_arbiter;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned LIMIT = 4;

  logic clock;
  logic reset;
  logic init_mem;
  logic [DW-1:0] mem [256];

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural single-port memory
  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 37 + 5);
    end else if (bus.mem_we) begin
      mem[bus.mem_address] <= bus.mem_data;
    end
  end
  assign bus.mem_q = mem[bus.mem_address];

  int checks;
  int errors;

  // Transfer-level reference model
  logic [DW-1:0] shadow [256];
  logic [AW-1:0] m_addr;
  int            m_left;
  bit            m_fill;
  int            m_denied;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  bit            m_done;
  bit            m_busy;

  // Observations for directed checks
  logic [DW-1:0] obs_rdata;
  bit            obs_stall, obs_wready, obs_done, obs_busy, obs_mem_we;
  int            stall_cnt, done_cnt, dump_cycles, rv_done;
  logic [DW-1:0] dump_seen [$];
  logic [AW-1:0] wr_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance model, return after posedge
  task automatic tick();
    bit            active, pend, req, frc, grant, nxt_rvalid, nxt_done;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_data, nxt_rdata;
    @(negedge clock);
    active = (m_left != 0);
    pend   = active && (!m_fill || bus.dbg_wvalid);
    req    = bus.cpu_re || bus.cpu_we;
    frc    = pend && (m_denied >= int'(LIMIT));
    grant  = pend && (!req || frc);
    e_addr = grant ? m_addr : bus.cpu_addr;
    e_we   = !reset && (grant ? m_fill : bus.cpu_we);
    e_data = grant ? bus.dbg_wdata : bus.cpu_wdata;

    chk("cpu_stall",   32'(bus.cpu_stall),   32'(req && grant));
    chk("dbg_wready",  32'(bus.dbg_wready),  32'(grant && m_fill));
    chk("mem_address", 32'(bus.mem_address), 32'(e_addr));
    chk("mem_we",      32'(bus.mem_we),      32'(e_we));
    chk("mem_data",    32'(bus.mem_data),    32'(e_data));
    chk("cpu_rdata",   32'(bus.cpu_rdata),   32'(shadow[e_addr]));
    chk("dbg_rvalid",  32'(bus.dbg_rvalid),  32'(m_rvalid));
    chk("dbg_rdata",   32'(bus.dbg_rdata),   32'(m_rdata));
    chk("dbg_done",    32'(bus.dbg_done),    32'(m_done));
    chk("dbg_busy",    32'(bus.dbg_busy),    32'(m_busy));

    obs_rdata  = bus.cpu_rdata;
    obs_stall  = bus.cpu_stall;
    obs_wready = bus.dbg_wready;
    obs_done   = bus.dbg_done;
    obs_busy   = bus.dbg_busy;
    obs_mem_we = bus.mem_we;
    if (bus.cpu_stall) stall_cnt++;
    if (bus.dbg_done) done_cnt++;
    if (bus.dbg_busy && !bus.dbg_done) dump_cycles++;
    if (bus.dbg_rvalid && bus.dbg_done) rv_done++;
    if (bus.dbg_rvalid) dump_seen.push_back(bus.dbg_rdata);
    if (bus.mem_we) wr_log.push_back(bus.mem_address);

    if (reset) begin
      m_left = 0; m_denied = 0; m_rvalid = 0; m_rdata = '0; m_done = 0; m_busy = 0; m_addr = '0;
    end else begin
      nxt_rvalid = grant && !m_fill;
      nxt_rdata  = nxt_rvalid ? shadow[m_addr] : m_rdata;
      if (e_we) shadow[e_addr] = e_data;
      nxt_done = 0;
      if (active) begin
        if (grant) begin
          m_addr++;
          m_left--;
          m_denied = 0;
          if (m_left == 0) nxt_done = 1;
        end else if (pend && m_denied < int'(LIMIT)) begin
          m_denied++;
        end
      end else if (bus.dbg_start && !m_done) begin
        m_addr   = bus.dbg_base;
        m_left   = int'(bus.dbg_len) + 1;
        m_fill   = bus.dbg_dir;
        m_denied = 0;
      end
      m_rvalid = nxt_rvalid;
      m_rdata  = nxt_rdata;
      m_done   = nxt_done;
      m_busy   = (m_left != 0) || nxt_done;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    tick();
    bus.cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.cpu_re = 1'b1; bus.cpu_addr = a;
    tick();
    bus.cpu_re = 1'b0;
    chk(name, 32'(obs_rdata), 32'(exp));
  endtask

  task automatic start(input bit dir, input logic [AW-1:0] base, input logic [AW-1:0] len);
    bus.dbg_start = 1'b1; bus.dbg_dir = dir; bus.dbg_base = base; bus.dbg_len = len;
    tick();
    bus.dbg_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      got = obs_done;
    end
    chk(name, 32'(got), 32'(1));
  endtask

  initial begin
    int k;
    checks = 0; errors = 0;
    reset = 1'b1; init_mem = 1'b1;
    bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_start = 0; bus.dbg_dir = 0; bus.dbg_base = '0; bus.dbg_len = '0;
    bus.dbg_wdata = '0; bus.dbg_wvalid = 0;
    for (int i = 0; i < 256; i++) shadow[i] = 16'(i * 37 + 5);
    m_addr = '0; m_left = 0; m_fill = 0; m_denied = 0;
    m_rvalid = 0; m_rdata = '0; m_done = 0; m_busy = 0;
    stall_cnt = 0; done_cnt = 0; dump_cycles = 0; rv_done = 0;

    tick();
    init_mem = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", 32'(obs_busy), 32'(0));
    chk("reset_done", 32'(obs_done), 32'(0));

    // Plain CPU write then read
    stall_cnt = 0;
    cpu_write(8'h10, 16'h00A5);
    cpu_read("cpu_rd_10", 8'h10, 16'h00A5);
    chk("cpu_no_stall", 32'(stall_cnt), 32'(0));

    // Fill wrapping past 0xFF
    start(1'b1, 8'hFE, 8'd3);
    wr_log.delete();
    bus.dbg_wvalid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.dbg_wdata = 16'(i);
      tick();
      chk("fill_wready", 32'(obs_wready), 32'(1));
    end
    bus.dbg_wvalid = 1'b0;
    tick();
    chk("fill_done", 32'(obs_done), 32'(1));
    chk("fill_nwr", 32'(wr_log.size()), 32'(4));
    if (wr_log.size() == 4) begin
      chk("fill_a0", 32'(wr_log[0]), 32'(8'hFE));
      chk("fill_a1", 32'(wr_log[1]), 32'(8'hFF));
      chk("fill_a2", 32'(wr_log[2]), 32'(8'h00));
      chk("fill_a3", 32'(wr_log[3]), 32'(8'h01));
    end
    cpu_read("fill_rd_fe", 8'hFE, 16'd1);
    cpu_read("fill_rd_ff", 8'hFF, 16'd2);
    cpu_read("fill_rd_00", 8'h00, 16'd3);
    cpu_read("fill_rd_01", 8'h01, 16'd4);

    // Dump of 8 words with CPU idle
    for (int i = 0; i < 8; i++) cpu_write(8'(8'h20 + i), 16'(16'h20 + i));
    start(1'b0, 8'h20, 8'd7);
    dump_seen.delete(); rv_done = 0;
    wait_done("dump8_done", 20);
    chk("dump8_n", 32'(dump_seen.size()), 32'(8));
    for (int i = 0; i < 8; i++)
      if (i < dump_seen.size()) chk("dump8_data", 32'(dump_seen[i]), 32'(16'h20 + i));
    chk("dump8_last_with_done", 32'(rv_done), 32'(1));

    // Starvation: CPU requests every cycle during a 2-word dump
    bus.cpu_re = 1'b1; bus.cpu_addr = 8'h55;
    start(1'b0, 8'h20, 8'd1);
    bus.cpu_re = 1'b1;
    stall_cnt = 0; dump_cycles = 0; dump_seen.delete();
    wait_done("starve_done", 40);
    bus.cpu_re = 1'b0;
    chk("starve_cycles", 32'(dump_cycles), 32'(10));
    chk("starve_stalls", 32'(stall_cnt), 32'(2));
    chk("starve_n", 32'(dump_seen.size()), 32'(2));
    if (dump_seen.size() == 2) chk("starve_d1", 32'(dump_seen[1]), 32'(16'h21));

    // Gappy fill under constant CPU load, stray dbg_start mid-transfer
    bus.cpu_re = 1'b1; bus.cpu_addr = 8'h00;
    start(1'b1, 8'h80, 8'd5);
    bus.cpu_re = 1'b1;
    done_cnt = 0; k = 0;
    bus.dbg_wdata = 16'hC000;
    for (int it = 0; it < 300 && k < 6; it++) begin
      bus.dbg_wvalid = ($urandom_range(0, 2) != 0);
      bus.dbg_start  = (it == 5);
      bus.dbg_dir    = 1'b0; bus.dbg_base = 8'h00; bus.dbg_len = 8'd0;
      tick();
      if (obs_wready) begin
        k++;
        bus.dbg_wdata = 16'(16'hC000 + k);
      end
    end
    bus.dbg_wvalid = 1'b0; bus.dbg_start = 1'b0; bus.cpu_re = 1'b0;
    tick();
    chk("gap_words", 32'(k), 32'(6));
    chk("gap_done_cnt", 32'(done_cnt), 32'(1));
    for (int i = 0; i < 6; i++) cpu_read("gap_rd", 8'(8'h80 + i), 16'(16'hC000 + i));

    // Reset in the middle of a fill
    start(1'b1, 8'h40, 8'd3);
    bus.dbg_wvalid = 1'b1;
    bus.dbg_wdata = 16'hAAA0; tick();
    bus.dbg_wdata = 16'hAAA1; tick();
    bus.dbg_wdata = 16'hAAA2;
    reset = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h41; bus.cpu_wdata = 16'hDEAD;
    done_cnt = 0;
    tick();
    chk("rst_mem_we", 32'(obs_mem_we), 32'(0));
    reset = 1'b0; bus.cpu_we = 1'b0; bus.dbg_wvalid = 1'b0;
    tick();
    chk("rst_busy", 32'(obs_busy), 32'(0));
    for (int i = 0; i < 3; i++) tick();
    chk("rst_no_done", 32'(done_cnt), 32'(0));
    start(1'b0, 8'h40, 8'd1);
    dump_seen.delete();
    wait_done("rst_dump_done", 10);
    chk("rst_dump_n", 32'(dump_seen.size()), 32'(2));
    if (dump_seen.size() == 2) begin
      chk("rst_dump_0", 32'(dump_seen[0]), 32'(16'hAAA0));
      chk("rst_dump_1", 32'(dump_seen[1]), 32'(16'hAAA1));
    end

    // Randomized soak against the model
    for (int it = 0; it < 2500; it++) begin
      bus.cpu_re     = ($urandom_range(0, 1) == 1);
      bus.cpu_we     = ($urandom_range(0, 3) == 0);
      bus.cpu_addr   = 8'($urandom);
      bus.cpu_wdata  = 16'($urandom);
      bus.dbg_start  = ($urandom_range(0, 29) == 0);
      bus.dbg_dir    = 1'($urandom);
      bus.dbg_base   = 8'($urandom);
      bus.dbg_len    = 8'($urandom_range(0, 15));
      bus.dbg_wdata  = 16'($urandom);
      bus.dbg_wvalid = ($urandom_range(0, 2) != 0);
      reset          = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 16-bit word, combinational read, write on clock edge) between two requesters: the CPU pipeline MEM stage and a debug block-transfer channel.
- The debug channel fills a memory region from a word stream or dumps a region to a word stream; this is used for test-program data load and post-run inspection.
- The CPU has priority. A starvation limit guarantees the debug channel forward progress by stalling the CPU for one cycle.

Parameters:
- AW, 8, memory address width.
- DW, 16, memory data width.
- STARVE_LIMIT, 4, number of consecutive cycles a pending debug access may be denied before it is forced through. Legal range is 1 or more.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_re  in  1  CPU read request this cycle.
- cpu_we  in  1  CPU write request this cycle.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data; combinational copy of mem_q.
- cpu_stall  out  1  CPU access not performed this cycle; the pipeline holds its request.
- dbg_start  in  1  one-cycle pulse; starts a transfer.
- dbg_dir  in  1  transfer direction: 1 = fill (write memory), 0 = dump (read memory).
- dbg_base  in  AW  transfer start address.
- dbg_len  in  AW  transfer length in words minus 1 (0 means 1 word, 255 means 256 words).
- dbg_wdata  in  DW  fill stream data.
- dbg_wvalid  in  1  fill stream data valid.
- dbg_wready  out  1  fill word accepted this cycle.
- dbg_rdata  out  DW  dump stream data (registered).
- dbg_rvalid  out  1  dump word valid (one-cycle pulse per word; no backpressure).
- dbg_busy  out  1  transfer in progress (high in FILL, DUMP and DONE).
- dbg_done  out  1  one-cycle pulse when a transfer completes.
- mem_address  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_data  out  DW  memory write data.
- mem_q  in  DW  memory read data (combinational with respect to mem_address).

Behaviour:
- Reset values: state IDLE, address pointer 0, remaining-word count 0, starve counter 0, dbg_rvalid 0, dbg_rdata 0, dbg_done 0.
- While reset is high, mem_we is forced to 0 regardless of any request, including CPU writes.

State machine (IDLE, FILL, DUMP, DONE):
- IDLE: on dbg_start, load pointer = dbg_base and count = dbg_len, then go to FILL if dbg_dir = 1, otherwise DUMP.
- dbg_start is ignored in every state other than IDLE.
- FILL / DUMP: on each debug access, pointer increments modulo 2^AW (255 wraps to 0). When the access is made with count = 0, go to DONE; otherwise count decrements.
- DONE: dbg_done = 1 for exactly one cycle, then IDLE.

Arbitration (combinational, evaluated each cycle):
- cpu_req = cpu_re | cpu_we.
- dbg_pend = (state == DUMP) | (state == FILL & dbg_wvalid).
- force = dbg_pend & (starve counter == STARVE_LIMIT).
- dbg_grant = dbg_pend & (~cpu_req | force).
- cpu_stall = cpu_req & dbg_grant. This is always 0 in IDLE and DONE.

Memory mux:
- When dbg_grant: mem_address = pointer; mem_we = (state == FILL); mem_data = dbg_wdata.
- Otherwise: mem_address = cpu_addr; mem_we = cpu_we; mem_data = cpu_wdata.
- If cpu_re and cpu_we are both high, the write takes effect and cpu_rdata shows the old contents.

Stream handshakes:
- dbg_wready = dbg_grant & (state == FILL). A fill word transfers when dbg_wvalid & dbg_wready.
- The path from cpu_re/cpu_we to dbg_wready is combinational.
- On a dump access, mem_q is registered into dbg_rdata and dbg_rvalid pulses in the next cycle.
- The final dump word's dbg_rvalid coincides with dbg_done. For a fill, dbg_done follows the last accepted word by one cycle.

Starve counter:
- Increments (saturating at STARVE_LIMIT) when dbg_pend & ~dbg_grant.
- Clears on any debug access and whenever the state is not FILL or DUMP.
- Holds while the FILL stream has dbg_wvalid low.

Reset mid-transfer: abort with no dbg_done, return to IDLE, and drop any pending dbg_rvalid. The next dbg_start after reset operates normally.

Test Plan:
- Reset, then CPU write 0x00A5 to address 0x10, then CPU read of 0x10 -> cpu_rdata = 0x00A5; cpu_stall stays 0; dbg_busy = 0.
- Fill with dbg_base = 0xFE, dbg_len = 3, CPU idle, dbg_wvalid held high with data 1, 2, 3, 4 -> writes to addresses 0xFE, 0xFF, 0x00, 0x01 in 4 consecutive cycles; dbg_done one cycle later; CPU reads of those addresses return 1..4.
- Dump with dbg_base = 0x20, dbg_len = 7, CPU idle, memory preloaded with 0x20+i -> 8 consecutive dbg_rvalid pulses with data 0x20..0x27; dbg_done coincides with the 8th pulse.
- STARVE_LIMIT = 4, CPU requesting every cycle, dump of 2 words -> after 4 denied cycles cpu_stall is high for exactly 1 cycle and the debug read occurs; the pattern repeats once; total 10 cycles to DONE.
- Fill with dbg_wvalid gaps while the CPU requests every cycle -> the starve counter holds during the gaps; dbg_start pulsed mid-transfer is ignored; all words are eventually written at the correct addresses.
- Reset asserted after 2 of 4 fill words -> mem_we = 0 in the reset cycle; dbg_busy = 0 the next cycle; no dbg_done; a subsequent dump of those 2 words returns the written data.
